// File: rtl/snn_x1_pkg.sv
// Shared types and constants for the X1 crossbar tile sequencer.
package snn_x1_pkg;

    localparam int N_TILES = 4;
    localparam int DW      = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    // Width of a counter that must be able to hold the value timeout_cycles.
    function automatic int timeout_cnt_w(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/snn_x1_tile_sequencer_if.sv
// Command, response and per-tile Wishbone bus bundle of the tile sequencer.
// The master modport is the sequencer's view; slave is the neuron core plus tiles.
interface snn_x1_tile_sequencer_if;
    import snn_x1_pkg::*;

    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic                    cmd_we_i;
    logic [N_TILES-1:0]      cmd_mask_i;
    logic [N_TILES*DW-1:0]   cmd_dat_i;

    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [N_TILES*DW-1:0]   rsp_dat_o;
    logic [N_TILES-1:0]      rsp_err_o;

    logic [N_TILES-1:0]      slave_cyc_o;
    logic [N_TILES-1:0]      slave_stb_o;
    logic                    slave_we_o;
    logic [N_TILES*DW-1:0]   slave_dat_o;
    logic [N_TILES*DW-1:0]   slave_dat_i;
    logic [N_TILES-1:0]      slave_ack_i;

    logic                    busy_o;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_mask_i, cmd_dat_i,
        input  rsp_ready_i, slave_dat_i, slave_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output slave_cyc_o, slave_stb_o, slave_we_o, slave_dat_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_mask_i, cmd_dat_i,
        output rsp_ready_i, slave_dat_i, slave_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  slave_cyc_o, slave_stb_o, slave_we_o, slave_dat_o, busy_o
    );

endinterface

// File: rtl/snn_x1_tile_port.sv
// Per-tile slice: pending flag (which is also the tile's cyc/stb), captured
// read data and timeout error flag.
module snn_x1_tile_port
    import snn_x1_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mask_bit,
    input  logic          issue,
    input  logic          expire,
    input  logic          we,
    input  logic          ack,
    input  logic [DW-1:0] rd_dat,
    output logic          pending,
    output logic [DW-1:0] dat,
    output logic          err
);

    // Arm on command accept; retire on ack (ack beats a simultaneous expiry) or on timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            dat     <= '0;
            err     <= 1'b0;
        end else if (start) begin
            pending <= mask_bit;
            dat     <= '0;
            err     <= 1'b0;
        end else if (issue && pending) begin
            if (ack) begin
                pending <= 1'b0;
                dat     <= we ? '0 : rd_dat;
            end else if (expire) begin
                pending <= 1'b0;
                err     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/snn_x1_tile_sequencer.sv
// Sequences one command at a time across the four X1 tiles, enforces a shared
// per-command timeout and returns one aggregated response.
module snn_x1_tile_sequencer
    import snn_x1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    snn_x1_tile_sequencer_if.master  bus
);

    localparam int             CW       = timeout_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic [CW-1:0]           tmo_cnt;
    logic                    cmd_ready_q;
    logic                    rsp_valid_q;
    logic                    busy_q;
    logic                    we_q;
    logic [N_TILES*DW-1:0]   wdat_q;

    logic                    accept;
    logic                    issue;
    logic                    expire;
    logic                    issue_done;
    logic [N_TILES-1:0]      pending;
    logic [N_TILES-1:0]      err;
    logic [N_TILES*DW-1:0]   cap_dat;

    // Handshake and timeout decode shared by the FSM and every tile slice.
    always_comb begin
        accept     = (state == IDLE) && cmd_ready_q && bus.cmd_valid_i;
        issue      = (state == ISSUE);
        expire     = issue && (tmo_cnt == LAST_CNT);
        issue_done = ((pending & ~bus.slave_ack_i) == '0) || expire;
    end

    // Command FSM with registered handshake outputs, latched write data and timeout counter.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            we_q        <= 1'b0;
            wdat_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q        <= bus.cmd_we_i;
                        wdat_q      <= bus.cmd_dat_i;
                        tmo_cnt     <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.cmd_mask_i != '0) begin
                            state <= ISSUE;
                        end else begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (issue_done) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < N_TILES; k++) begin : g_tile
        snn_x1_tile_port u_port (
            .clk      (wb_clk_i),
            .rst      (wb_rst_i),
            .start    (accept),
            .mask_bit (bus.cmd_mask_i[k]),
            .issue    (issue),
            .expire   (expire),
            .we       (we_q),
            .ack      (bus.slave_ack_i[k]),
            .rd_dat   (bus.slave_dat_i[k*DW +: DW]),
            .pending  (pending[k]),
            .dat      (cap_dat[k*DW +: DW]),
            .err      (err[k])
        );
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.rsp_dat_o   = cap_dat;
    assign bus.rsp_err_o   = err;
    assign bus.slave_cyc_o = pending;
    assign bus.slave_stb_o = pending;
    assign bus.slave_we_o  = we_q;
    assign bus.slave_dat_o = wdat_q;

endmodule

// File: tb/tb_snn_x1_tile_sequencer.sv
// Bench for the X1 tile sequencer: directed corner cases followed by random
// commands, each checked against a per-command model of acks, timeouts and latency.
module tb_snn_x1_tile_sequencer;
    import snn_x1_pkg::*;

    localparam int TO = 8;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;

    int tests    = 0;
    int failures = 0;

    // Tile behaviour for the next command: cycle (1 = first stb cycle) at which
    // each tile acks, and the word it returns on that ack.
    int          ack_at[4];
    logic [31:0] rd_word[4];

    snn_x1_tile_sequencer_if bus();

    snn_x1_tile_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    // Free-running clock.
    always #5 wb_clk_i = ~wb_clk_i;

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] want);
        tests++;
        assert (obs === want) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Run one command end to end and compare against the model.
    task automatic applyStimulus(input logic we, input logic [3:0] mask,
                                 input logic [127:0] wdat, input int hold);
        logic [127:0] want_dat;
        logic [3:0]   want_err;
        int           want_stb[4];
        int           want_lat;
        int           eff;
        int           stb_cnt[4];
        int           lat;
        bit           seen;
        int           bus_bad;
        int           cyc_bad;
        int           unstable;
        int           ready_bad;
        logic [3:0]   a;

        want_dat = '0;
        want_err = '0;
        want_lat = 1;
        for (int k = 0; k < 4; k++) begin
            want_stb[k] = 0;
            stb_cnt[k]  = 0;
            if (mask[k]) begin
                eff         = (ack_at[k] > TO) ? TO : ack_at[k];
                want_stb[k] = eff;
                if (ack_at[k] > TO) want_err[k] = 1'b1;
                else if (!we)       want_dat[k*32 +: 32] = rd_word[k];
                if (eff + 1 > want_lat) want_lat = eff + 1;
            end
        end

        @(negedge wb_clk_i);
        checkOutput("cmd_ready_idle", bus.cmd_ready_o, 1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_mask_i  = mask;
        bus.cmd_dat_i   = wdat;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = ~we;
        bus.cmd_mask_i  = 4'($urandom);
        bus.cmd_dat_i   = {$urandom, $urandom, $urandom, $urandom};

        seen    = 1'b0;
        lat     = 0;
        bus_bad = 0;
        cyc_bad = 0;
        for (int c = 1; c <= TO + 4 && !seen; c++) begin
            if (bus.rsp_valid_o) begin
                seen = 1'b1;
                lat  = c;
            end
            for (int k = 0; k < 4; k++) stb_cnt[k] += int'(bus.slave_stb_o[k]);
            if (bus.slave_cyc_o !== bus.slave_stb_o) cyc_bad++;
            if (bus.slave_stb_o != 4'h0 && (bus.slave_we_o !== we || bus.slave_dat_o !== wdat))
                bus_bad++;
            if (!seen) begin
                for (int k = 0; k < 4; k++) begin
                    a[k] = (c == ack_at[k]) ||
                           ((!mask[k] || c > ack_at[k]) && ($urandom_range(0, 1) == 1));
                    bus.slave_dat_i[k*32 +: 32] = (c == ack_at[k]) ? rd_word[k] : $urandom;
                end
                bus.slave_ack_i = a;
                @(posedge wb_clk_i);
                @(negedge wb_clk_i);
            end
        end
        bus.slave_ack_i = 4'h0;

        checkOutput("rsp_valid_seen", seen, 1);
        checkOutput("rsp_latency", lat, want_lat);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("stb_cycles_t%0d", k), stb_cnt[k], want_stb[k]);
        checkOutput("cyc_eq_stb", cyc_bad, 0);
        checkOutput("bus_we_dat_hold", bus_bad, 0);
        checkOutput("rsp_dat", bus.rsp_dat_o, want_dat);
        checkOutput("rsp_err", bus.rsp_err_o, want_err);
        checkOutput("busy_resp", bus.busy_o, 1);
        checkOutput("cmd_ready_resp", bus.cmd_ready_o, 0);

        unstable  = 0;
        ready_bad = 0;
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid_i = 1'b1;
            bus.cmd_mask_i  = 4'hF;
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if (!bus.rsp_valid_o || bus.rsp_dat_o !== want_dat || bus.rsp_err_o !== want_err)
                unstable++;
            if (bus.cmd_ready_o) ready_bad++;
        end
        if (hold > 0) begin
            checkOutput("rsp_stable_hold", unstable, 0);
            checkOutput("cmd_ready_hold", ready_bad, 0);
        end

        bus.rsp_ready_i = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        bus.rsp_ready_i = 1'b0;
        bus.cmd_valid_i = 1'b0;
        checkOutput("cmd_ready_after", bus.cmd_ready_o, 1);
        checkOutput("rsp_valid_after", bus.rsp_valid_o, 0);
        checkOutput("busy_after", bus.busy_o, 0);
    endtask

    initial begin
        logic [127:0] wd;
        logic [3:0]   m;
        int           rv_cnt;

        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_mask_i  = 4'h0;
        bus.cmd_dat_i   = '0;
        bus.rsp_ready_i = 1'b0;
        bus.slave_dat_i = '0;
        bus.slave_ack_i = 4'h0;

        // Reset values
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        checkOutput("rst_cmd_ready", bus.cmd_ready_o, 1);
        checkOutput("rst_rsp_valid", bus.rsp_valid_o, 0);
        checkOutput("rst_rsp_dat", bus.rsp_dat_o, 0);
        checkOutput("rst_rsp_err", bus.rsp_err_o, 0);
        checkOutput("rst_cyc", bus.slave_cyc_o, 0);
        checkOutput("rst_stb", bus.slave_stb_o, 0);
        checkOutput("rst_we", bus.slave_we_o, 0);
        checkOutput("rst_slave_dat", bus.slave_dat_o, 0);
        checkOutput("rst_busy", bus.busy_o, 0);
        wb_rst_i = 1'b0;

        // Write to all tiles, every tile acks in its first stb cycle
        for (int k = 0; k < 4; k++) begin ack_at[k] = 1; rd_word[k] = $urandom; end
        applyStimulus(1'b1, 4'hF, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 0);

        // Read tiles 0 and 2 with staggered acks; response held off for 10 cycles
        ack_at  = '{1, 100, 5, 100};
        rd_word = '{32'hA5A5_0000, 32'hDEAD_BEEF, 32'h0000_5A5A, 32'hCAFE_F00D};
        applyStimulus(1'b0, 4'b0101, {$urandom, $urandom, $urandom, $urandom}, 10);

        // Tile 3 never acks: times out
        ack_at  = '{2, 3, 1, 100};
        rd_word = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004};
        applyStimulus(1'b0, 4'hF, '0, 0);

        // Tile 3 ack lands exactly on the expiry cycle
        ack_at  = '{4, 2, 6, TO};
        applyStimulus(1'b0, 4'hF, '0, 1);

        // Empty mask
        applyStimulus(1'b0, 4'h0, {$urandom, $urandom, $urandom, $urandom}, 2);

        // Random commands
        for (int t = 0; t < 20; t++) begin
            m  = 4'($urandom_range(0, 15));
            wd = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 4; k++) begin
                ack_at[k]  = $urandom_range(1, TO + 2);
                rd_word[k] = $urandom;
            end
            applyStimulus(1'($urandom_range(0, 1)), m, wd, $urandom_range(0, 3));
        end

        // Reset asserted during ISSUE with all strobes up
        @(negedge wb_clk_i);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b1;
        bus.cmd_mask_i  = 4'hF;
        bus.cmd_dat_i   = {$urandom, $urandom, $urandom, $urandom};
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        bus.cmd_valid_i = 1'b0;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        checkOutput("midrst_pre_stb", bus.slave_stb_o, 4'hF);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        checkOutput("midrst_stb", bus.slave_stb_o, 0);
        checkOutput("midrst_cyc", bus.slave_cyc_o, 0);
        checkOutput("midrst_cmd_ready", bus.cmd_ready_o, 1);
        checkOutput("midrst_rsp_valid", bus.rsp_valid_o, 0);
        checkOutput("midrst_busy", bus.busy_o, 0);
        checkOutput("midrst_we", bus.slave_we_o, 0);
        checkOutput("midrst_slave_dat", bus.slave_dat_o, 0);
        rv_cnt = 0;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if (bus.rsp_valid_o || bus.busy_o) rv_cnt++;
        end
        bus.rsp_ready_i = 1'b0;
        checkOutput("midrst_no_rsp", rv_cnt, 0);

        // Normal operation resumes after reset
        for (int k = 0; k < 4; k++) begin ack_at[k] = k + 1; rd_word[k] = $urandom; end
        applyStimulus(1'b0, 4'b1011, '0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
